// File: rtl/ppg_pkg.sv
// Shared types and default constants for the PPG beat detector.
// Optional adaptive hysteresis is enabled by defining PPG_AUTO_HYST_EN.
package ppg_pkg;
  typedef enum logic [1:0] {FILL, FALLING, RISING} ppg_state_e;

  localparam int ADC_W            = 8;
  localparam int AVG_LOG2_DEF     = 2;
  localparam int HYST_DEF         = 8;
  localparam int MIN_INTERVAL_DEF = 30;
  localparam int MAX_INTERVAL_DEF = 300;
  localparam int CNT_W_DEF        = 16;
endpackage

// File: rtl/ppg_beat_detector_if.sv
// Sample stream in, beat reports out; master drives samples, slave is the detector.
interface ppg_beat_detector_if import ppg_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
);
  logic             sample_valid;
  logic [ADC_W-1:0] IR_ADC_Value;
  logic             beat_pulse;
  logic [CNT_W-1:0] beat_interval;
  logic             interval_valid;
  logic [ADC_W-1:0] beat_amplitude;
  logic             signal_lost;

  modport master (
    output sample_valid, IR_ADC_Value,
    input  beat_pulse, beat_interval, interval_valid, beat_amplitude, signal_lost
  );
  modport slave (
    input  sample_valid, IR_ADC_Value,
    output beat_pulse, beat_interval, interval_valid, beat_amplitude, signal_lost
  );
endinterface

// File: rtl/ppg_moving_avg.sv
// Boxcar average over 2^AVG_LOG2 samples; avg_o is valid the cycle after the sample strobe.
module ppg_moving_avg import ppg_pkg::*; #(
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid_i,
  input  logic [ADC_W-1:0] sample_i,
  output logic [ADC_W-1:0] avg_o,
  output logic             avg_valid_o,
  output logic             full_o
);
  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = ADC_W + AVG_LOG2;

  logic [N-1:0][ADC_W-1:0] win_q, win_d;
  logic [SW-1:0]           sum_q, sum_d;
  logic [ADC_W-1:0]        avg_q, avg_d;
  logic [AVG_LOG2:0]       fill_q, fill_d;
  logic                    vld_q;

  // Window starts zeroed, so the running sum stays exact from the first sample.
  always_comb begin
    win_d  = {win_q[N-2:0], sample_i};
    sum_d  = sum_q + SW'(sample_i) - SW'(win_q[N-1]);
    avg_d  = sum_d[SW-1:AVG_LOG2];
    fill_d = (fill_q == (AVG_LOG2+1)'(N)) ? fill_q : fill_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      sum_q  <= '0;
      avg_q  <= '0;
      fill_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= sample_valid_i;
      if (sample_valid_i) begin
        win_q  <= win_d;
        sum_q  <= sum_d;
        avg_q  <= avg_d;
        fill_q <= fill_d;
      end
    end
  end

  assign avg_o       = avg_q;
  assign avg_valid_o = vld_q;
  assign full_o      = (fill_q == (AVG_LOG2+1)'(N));
endmodule

// File: rtl/ppg_beat_detector.sv
// Peak detector on the smoothed IR stream: hysteresis turns, refractory rejection, loss timeout.
// Define PPG_AUTO_HYST_EN to scale hysteresis with the last accepted beat amplitude.
module ppg_beat_detector import ppg_pkg::*; #(
  parameter int AVG_LOG2     = AVG_LOG2_DEF,
  parameter int HYST         = HYST_DEF,
  parameter int MIN_INTERVAL = MIN_INTERVAL_DEF,
  parameter int MAX_INTERVAL = MAX_INTERVAL_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                CLK,
  input  logic                rst_n,
  ppg_beat_detector_if.slave  bus
);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_INTERVAL);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INTERVAL);

  logic [ADC_W-1:0] avg;
  logic             avg_valid, full;

  ppg_moving_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk            (CLK),
    .rst_n          (rst_n),
    .sample_valid_i (bus.sample_valid),
    .sample_i       (bus.IR_ADC_Value),
    .avg_o          (avg),
    .avg_valid_o    (avg_valid),
    .full_o         (full)
  );

  ppg_state_e       state_q, state_d;
  logic [ADC_W-1:0] min_q, min_d, max_q, max_d, amp_q, amp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, intv_q, intv_d, cnt_inc;
  logic             prev_q, prev_d, lost_q, lost_d, pulse_q, pulse_d, ivld_q, ivld_d;
  logic             accept, sat_now;
  logic [8:0]       hyst;

`ifdef PPG_AUTO_HYST_EN
  logic [ADC_W-1:0] hamp_q, hamp_d;

  always_comb begin
    hyst = ({3'b0, hamp_q[ADC_W-1:2]} > 9'(HYST)) ? {3'b0, hamp_q[ADC_W-1:2]} : 9'(HYST);
    hamp_d = hamp_q;
    if (accept)               hamp_d = max_q - min_q;
    else if (lost_d && !lost_q) hamp_d = '0;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) hamp_q <= '0;
    else        hamp_q <= hamp_d;
  end
`else
  assign hyst = 9'(HYST);
`endif

  assign cnt_inc = (cnt_q >= MAX_C) ? MAX_C : cnt_q + CNT_W'(1);
  assign sat_now = (cnt_inc == MAX_C);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    lost_d  = lost_q;
    pulse_d = 1'b0;
    intv_d  = intv_q;
    ivld_d  = ivld_q;
    amp_d   = amp_q;
    accept  = 1'b0;
    if (avg_valid) begin
      case (state_q)
        FILL: if (full) begin
          state_d = FALLING;
          min_d   = avg;
          max_d   = avg;
        end
        FALLING: begin
          cnt_d = cnt_inc;
          if (avg < min_q) min_d = avg;
          if ({1'b0, avg} >= {1'b0, min_q} + hyst) begin
            state_d = RISING;
            max_d   = avg;
          end
        end
        RISING: begin
          cnt_d = cnt_inc;
          if (avg > max_q) max_d = avg;
          // Peaks inside the refractory window drop back to FALLING without resetting the count.
          if ({1'b0, avg} + hyst <= {1'b0, max_q}) begin
            state_d = FALLING;
            min_d   = avg;
            accept  = (cnt_q >= MIN_C);
          end
        end
        default: state_d = FILL;
      endcase

      if (accept) begin
        pulse_d = 1'b1;
        amp_d   = max_q - min_q;
        cnt_d   = CNT_W'(1);
        prev_d  = 1'b1;
        lost_d  = 1'b0;
        if (prev_q && !lost_q && !sat_now) begin
          intv_d = cnt_q;
          ivld_d = 1'b1;
        end else begin
          ivld_d = 1'b0;
        end
      end else if (state_q != FILL && sat_now) begin
        lost_d = 1'b1;
        prev_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      min_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      lost_q  <= 1'b0;
      pulse_q <= 1'b0;
      intv_q  <= '0;
      ivld_q  <= 1'b0;
      amp_q   <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      lost_q  <= lost_d;
      pulse_q <= pulse_d;
      intv_q  <= intv_d;
      ivld_q  <= ivld_d;
      amp_q   <= amp_d;
    end
  end

  assign bus.beat_pulse     = pulse_q;
  assign bus.beat_interval  = intv_q;
  assign bus.interval_valid = ivld_q;
  assign bus.beat_amplitude = amp_q;
  assign bus.signal_lost    = lost_q;
endmodule

// File: tb/tb_ppg_beat_detector.sv
// Directed bench: fill, ripple rejection, triangle beats, refractory spike, signal loss, async reset.
module tb_ppg_beat_detector;
  import ppg_pkg::*;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  ppg_beat_detector_if #(.CNT_W(16)) bus ();

  ppg_beat_detector dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   beats = 0;
  int   b0;
  logic pulse2;
  logic saw_rising;

  always @(negedge CLK) if (bus.beat_pulse === 1'b1) beats++;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sample every 10 clocks; pulse2 captures beat_pulse two cycles after the strobe.
  task automatic send(input logic [7:0] x);
    @(negedge CLK);
    bus.sample_valid = 1'b1;
    bus.IR_ADC_Value = x;
    @(negedge CLK);
    bus.sample_valid = 1'b0;
    @(negedge CLK);
    pulse2 = bus.beat_pulse;
    repeat (7) @(negedge CLK);
  endtask

  function automatic logic [7:0] tri_x(input int p);
    int q;
    q = p % 100;
    if (q <= 50) return 8'(50 + 3 * q);
    else         return 8'(350 - 3 * q);
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    rst_n = 1'b0;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
  endtask

  task automatic chk_beat(input string tag, input int intv, input int ivld, input int amp);
    chk({tag, "_pulse"}, 32'(pulse2), 1);
    chk({tag, "_intv"},  32'(bus.beat_interval), 32'(intv));
    chk({tag, "_ivld"},  32'(bus.interval_valid), 32'(ivld));
    chk({tag, "_amp"},   32'(bus.beat_amplitude), 32'(amp));
    chk({tag, "_lost"},  32'(bus.signal_lost), 0);
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.IR_ADC_Value = '0;
    repeat (3) @(negedge CLK);
    chk("rst_pulse", 32'(bus.beat_pulse), 0);
    chk("rst_intv",  32'(bus.beat_interval), 0);
    chk("rst_amp",   32'(bus.beat_amplitude), 0);
    chk("rst_lost",  32'(bus.signal_lost), 0);
    chk("rst_state", 32'(dut.state_q), 32'(FILL));
    rst_n = 1'b1;

    // Fill: FSM leaves FILL exactly on the 4th sample
    b0 = beats;
    repeat (3) send(8'd100);
    chk("fill3_state", 32'(dut.state_q), 32'(FILL));
    send(8'd100);
    chk("fill4_state", 32'(dut.state_q), 32'(FALLING));
    chk("fill_beats",  32'(beats), 32'(b0));
    chk("fill_amp",    32'(bus.beat_amplitude), 0);
    chk("fill_ivld",   32'(bus.interval_valid), 0);

    // Slow +/-3 ripple around 128: averaged swing of 6 stays under hysteresis
    do_reset();
    b0 = beats;
    saw_rising = 1'b0;
    for (int i = 0; i < 48; i++) begin
      send(((i / 4) % 2) ? 8'd131 : 8'd125);
      if (dut.state_q == RISING) saw_rising = 1'b1;
    end
    chk("ripple_rise",  32'(saw_rising), 0);
    chk("ripple_beats", 32'(beats), 32'(b0));

    // Triangle 50..200, period 100
    do_reset();
    b0 = beats;
    for (int n = 0; n < 55; n++) send(tri_x(n));
    chk("tri_early_beats", 32'(beats), 32'(b0));
    send(tri_x(55));
    chk_beat("beat1", 0, 0, 143);
    for (int n = 56; n < 155; n++) send(tri_x(n));
    chk("tri_mid_beats", 32'(beats), 32'(b0 + 1));
    send(tri_x(155));
    chk_beat("beat2", 100, 1, 144);

    // +40 spike 10 samples after the peak: rises, then rejected as refractory
    for (int n = 156; n < 255; n++) begin
      if (n >= 160 && n <= 163) send(8'(int'(tri_x(n)) + 40));
      else                      send(tri_x(n));
      if (n == 163) chk("spike_rising", 32'(dut.state_q), 32'(RISING));
    end
    chk("spike_beats", 32'(beats), 32'(b0 + 2));
    send(tri_x(255));
    chk_beat("beat3", 100, 1, 144);

    // Flat input until the interval counter saturates
    for (int i = 1; i <= 298; i++) send(8'd128);
    chk("flat298_lost", 32'(bus.signal_lost), 0);
    send(8'd128);
    chk("flat299_lost", 32'(bus.signal_lost), 1);
    send(8'd128);
    chk("flat_beats", 32'(beats), 32'(b0 + 3));
    for (int p = 0; p < 55; p++) send(tri_x(p));
    chk("relock_lost_hold", 32'(bus.signal_lost), 1);
    send(tri_x(55));
    chk_beat("relock", 100, 0, 143);

    // Async reset while RISING
    for (int p = 56; p <= 130; p++) send(tri_x(p));
    chk("pre_rst_state", 32'(dut.state_q), 32'(RISING));
    @(negedge CLK);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_intv",  32'(bus.beat_interval), 0);
    chk("arst_amp",   32'(bus.beat_amplitude), 0);
    chk("arst_state", 32'(dut.state_q), 32'(FILL));
    chk("arst_lost",  32'(bus.signal_lost), 0);
    @(negedge CLK);
    rst_n = 1'b1;
    b0 = beats;
    for (int p = 0; p < 3; p++) send(tri_x(p));
    chk("refill3_state", 32'(dut.state_q), 32'(FILL));
    send(tri_x(3));
    chk("refill4_state", 32'(dut.state_q), 32'(FALLING));
    for (int p = 4; p < 55; p++) send(tri_x(p));
    chk("refill_beats", 32'(beats), 32'(b0));
    send(tri_x(55));
    chk_beat("post_rst", 0, 0, 143);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
